// File: rtl/mau_pkg.sv
// Shared encodings for the memory access unit: operations, FSM states,
// byte-lane enables and post-increment sizes.
package mau_pkg;

  typedef enum logic [1:0] {
    OP_LDW = 2'b00,
    OP_LDB = 2'b01,
    OP_STW = 2'b10,
    OP_STB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  localparam logic [1:0]  BE_UPPER = 2'b10;
  localparam logic [1:0]  BE_LOWER = 2'b01;
  localparam logic [1:0]  BE_WORD  = 2'b11;

  localparam logic [15:0] INC_WORD = 16'd2;
  localparam logic [15:0] INC_BYTE = 16'd1;

  // op[1] selects store, op[0] selects byte size
  function automatic logic op_is_store(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_byte(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mau_lane_mux.sv
// Big-endian byte-lane steering: byte enables, store replication and
// load byte extraction (address bit 0 = 0 is the upper lane).
module mau_lane_mux
  import mau_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic        i_addr_lsb,
  input  logic [15:0] i_s_bus,
  input  logic [15:0] i_rdata,
  output logic [1:0]  o_be,
  output logic [15:0] o_wdata,
  output logic [15:0] o_ldata
);

  logic [7:0] w_sel_byte;

  always_comb begin
    o_be       = BE_WORD;
    o_wdata    = i_s_bus;
    o_ldata    = i_rdata;
    w_sel_byte = i_addr_lsb ? i_rdata[7:0] : i_rdata[15:8];
    if (op_is_byte(i_op)) begin
      o_be    = i_addr_lsb ? BE_LOWER : BE_UPPER;
      o_wdata = {i_s_bus[7:0], i_s_bus[7:0]};
      o_ldata = {w_sel_byte, w_sel_byte};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store stage: one 16-bit req/ack memory transaction per start, with
// register-file writeback and optional post-increment. Define MAU_TIMEOUT_EN
// to abort a request that is not acknowledged within TIMEOUT_CYC cycles.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic              post_inc,
  input  logic [DATA_W-1:0] r_bus,
  input  logic [DATA_W-1:0] s_bus,
  input  logic [REG_AW-1:0] dst_idx,
  input  logic [REG_AW-1:0] base_idx,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] d_bus,
  output logic [REG_AW-1:0] d_idx,
  output logic              d_writeu,
  output logic              d_writel,
  output logic [DATA_W-1:0] a_bus,
  output logic [REG_AW-1:0] a_idx,
  output logic              a_write
);

  if (DATA_W != 16 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_param
    $error("mem_access_unit: unsupported DATA_W or TIMEOUT_CYC");
  end

  state_e            r_state;
  logic [1:0]        r_op;
  logic              r_addr0;
  logic              r_post;
  logic [REG_AW-1:0] r_dst;
  logic [REG_AW-1:0] r_base;
  logic              r_busy, r_done, r_err;
  logic              r_mem_req, r_mem_we;
  logic [1:0]        r_mem_be;
  logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;
  logic [DATA_W-1:0] r_d_bus, r_a_bus;
  logic              r_writeu, r_writel, r_a_write;
`ifdef MAU_TIMEOUT_EN
  logic [7:0]        r_cnt;
`endif

  logic              w_idle;
  logic [1:0]        w_op_sel;
  logic              w_lsb_sel;
  logic [1:0]        w_be;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ldata;
  logic              w_misalign;
  logic              w_is_load;

  // Steering uses live inputs at launch and the latched op during REQ.
  assign w_idle     = (r_state == ST_IDLE);
  assign w_op_sel   = w_idle ? op : r_op;
  assign w_lsb_sel  = w_idle ? r_bus[0] : r_addr0;
  assign w_misalign = !op_is_byte(op) && r_bus[0];
  assign w_is_load  = !op_is_store(r_op);

  mau_lane_mux u_lane_mux (
    .i_op       (w_op_sel),
    .i_addr_lsb (w_lsb_sel),
    .i_s_bus    (s_bus),
    .i_rdata    (mem_rdata),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .o_ldata    (w_ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_LDW;
      r_addr0     <= 1'b0;
      r_post      <= 1'b0;
      r_dst       <= '0;
      r_base      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_d_bus     <= '0;
      r_a_bus     <= '0;
      r_writeu    <= 1'b0;
      r_writel    <= 1'b0;
      r_a_write   <= 1'b0;
`ifdef MAU_TIMEOUT_EN
      r_cnt       <= 8'd0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_addr0 <= r_bus[0];
            r_post  <= post_inc;
            r_dst   <= dst_idx;
            r_base  <= base_idx;
            r_a_bus <= r_bus + (op_is_byte(op) ? INC_BYTE : INC_WORD);
            r_busy  <= 1'b1;
            if (w_misalign) begin
              r_state <= ST_WB;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state     <= ST_REQ;
              r_mem_req   <= 1'b1;
              r_mem_we    <= op_is_store(op);
              r_mem_be    <= w_be;
              r_mem_addr  <= {r_bus[DATA_W-1:1], 1'b0};
              r_mem_wdata <= w_wdata;
`ifdef MAU_TIMEOUT_EN
              r_cnt       <= 8'd0;
`endif
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            r_state   <= ST_WB;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_d_bus   <= w_ldata;
            r_writeu  <= w_is_load && !op_is_byte(r_op);
            r_writel  <= w_is_load;
            // a load into its own base register keeps the load data
            r_a_write <= r_post && !(w_is_load && (r_base == r_dst));
          end
`ifdef MAU_TIMEOUT_EN
          else if (r_cnt == 8'(TIMEOUT_CYC - 1)) begin
            r_state   <= ST_WB;
            r_mem_req <= 1'b0;
            r_done    <= 1'b1;
            r_err     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        ST_WB: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_err     <= 1'b0;
          r_writeu  <= 1'b0;
          r_writel  <= 1'b0;
          r_a_write <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign d_bus     = r_d_bus;
  assign d_idx     = r_dst;
  assign d_writeu  = r_writeu;
  assign d_writel  = r_writel;
  assign a_bus     = r_a_bus;
  assign a_idx     = r_base;
  assign a_write   = r_a_write;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit; cycle 0 is the start-accept cycle.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        post_inc = 1'b0;
  logic [15:0] r_bus = '0;
  logic [15:0] s_bus = '0;
  logic [3:0]  dst_idx = '0;
  logic [3:0]  base_idx = '0;
  logic        busy, done, err, mem_req, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [15:0] d_bus, a_bus;
  logic [3:0]  d_idx, a_idx;
  logic        d_writeu, d_writel, a_write;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .post_inc(post_inc),
    .r_bus(r_bus), .s_bus(s_bus), .dst_idx(dst_idx), .base_idx(base_idx),
    .busy(busy), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .d_bus(d_bus), .d_idx(d_idx),
    .d_writeu(d_writeu), .d_writel(d_writel), .a_bus(a_bus), .a_idx(a_idx),
    .a_write(a_write)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  int          o_done_cyc, o_req_cyc;
  logic [15:0] o_addr, o_wdata, o_dbus, o_abus;
  logic [1:0]  o_be;
  logic        o_we, o_err, o_wu, o_wl, o_aw, o_stable, o_busy1;
  logic [3:0]  o_didx, o_aidx;
  logic [5:0]  o_after;

  task automatic run_op(input logic [1:0] t_op, input logic [15:0] t_addr, input logic [15:0] t_sdata,
                        input logic t_post, input logic [3:0] t_dst, input logic [3:0] t_base,
                        input int t_ack, input logic [15:0] t_rdata, input logic t_hold, input int t_budget);
    o_done_cyc = -1; o_req_cyc = 0; o_stable = 1'b1; o_busy1 = 1'b0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    o_err = 1'b0; o_wu = 1'b0; o_wl = 1'b0; o_aw = 1'b0;
    o_dbus = '0; o_abus = '0; o_didx = '0; o_aidx = '0;
    @(negedge clk);
    start = 1'b1; op = t_op; r_bus = t_addr; s_bus = t_sdata;
    post_inc = t_post; dst_idx = t_dst; base_idx = t_base;
    @(posedge clk); #1;
    if (t_hold) begin
      op = ~t_op; r_bus = ~t_addr & 16'hFFFE; s_bus = ~t_sdata;
    end else begin
      start = 1'b0;
    end
    for (int cyc = 1; cyc <= t_budget; cyc++) begin
      mem_ack   = (cyc == t_ack);
      mem_rdata = (cyc == t_ack) ? t_rdata : 16'h5A5A;
      @(negedge clk);
      if (cyc == 1) o_busy1 = busy;
      if (mem_req) begin
        if (o_req_cyc == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_be = mem_be; o_we = mem_we;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wdata || mem_be !== o_be) begin
          o_stable = 1'b0;
        end
        o_req_cyc++;
      end
      if (done) begin
        o_done_cyc = cyc; o_err = err; o_wu = d_writeu; o_wl = d_writel; o_aw = a_write;
        o_dbus = d_bus; o_abus = a_bus; o_didx = d_idx; o_aidx = a_idx;
        start = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    o_after = {done, busy, mem_req, d_writeu, d_writel, a_write};
  endtask

  logic [5:0] acc;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, err, mem_req, d_writeu, d_writel, a_write}, 0);
    @(negedge clk) rst_n = 1'b1;

    // LDW 0x1000, ack at cycle 1
    run_op(2'b00, 16'h1000, 16'h0000, 1'b0, 4'd7, 4'd0, 1, 16'hBEEF, 1'b0, 50);
    check("ldw_done_cyc", o_done_cyc, 2);
    check("ldw_dbus", o_dbus, 16'hBEEF);
    check("ldw_strobes", {o_wu, o_wl, o_aw, o_err}, 4'b1100);
    check("ldw_mem", {o_be, o_we, o_addr}, {2'b11, 1'b0, 16'h1000});
    check("ldw_didx_busy", {o_didx, o_busy1}, {4'd7, 1'b1});
    check("ldw_after", o_after, 0);

    // LDB odd address with post-increment
    run_op(2'b01, 16'h2001, 16'h0000, 1'b1, 4'd5, 4'd3, 1, 16'h12AB, 1'b0, 50);
    check("ldb_dbus", o_dbus, 16'hABAB);
    check("ldb_strobes", {o_wu, o_wl, o_aw}, 3'b011);
    check("ldb_abus", {o_abus, o_aidx, o_didx}, {16'h2002, 4'd3, 4'd5});
    check("ldb_mem", {o_be, o_addr}, {2'b01, 16'h2000});

    // LDB even address picks the upper lane
    run_op(2'b01, 16'h2000, 16'h0000, 1'b0, 4'd1, 4'd0, 2, 16'h12AB, 1'b0, 50);
    check("ldb_even_dbus", o_dbus, 16'h1212);
    check("ldb_even_be_done", {o_be, 8'(o_done_cyc)}, {2'b10, 8'd3});

    // STB with ack at cycle 4, start held high and inputs changed while busy
    run_op(2'b11, 16'h3000, 16'h00C3, 1'b0, 4'd0, 4'd0, 4, 16'hFFFF, 1'b1, 50);
    check("stb_wdata", o_wdata, 16'hC3C3);
    check("stb_be_we", {o_be, o_we}, {2'b10, 1'b1});
    check("stb_req_cycles", o_req_cyc, 4);
    check("stb_done_cyc", o_done_cyc, 5);
    check("stb_no_dwrite", {o_wu, o_wl, o_aw}, 3'b000);
    check("stb_stable_ignore_start", o_stable, 1'b1);
    check("stb_after", o_after, 0);

    // STW aligned with post-increment
    run_op(2'b10, 16'h0104, 16'h1234, 1'b1, 4'd2, 4'd6, 1, 16'h0000, 1'b0, 50);
    check("stw_mem", {o_be, o_we, o_wdata}, {2'b11, 1'b1, 16'h1234});
    check("stw_post", {o_wu, o_wl, o_aw, o_abus, o_aidx}, {3'b001, 16'h0106, 4'd6});

    // STW misaligned: error, no access, no writes
    run_op(2'b10, 16'h0005, 16'h1111, 1'b1, 4'd1, 4'd1, -1, 16'h0000, 1'b0, 50);
    check("mis_req_cycles", o_req_cyc, 0);
    check("mis_done_cyc", o_done_cyc, 1);
    check("mis_err_writes", {o_err, o_wu, o_wl, o_aw}, 4'b1000);
    check("mis_after", o_after, 0);

    // LDW 0xFFFE into its own base register
    run_op(2'b00, 16'hFFFE, 16'h0000, 1'b1, 4'd2, 4'd2, 1, 16'h4321, 1'b0, 50);
    check("same_idx_writes", {o_wu, o_wl, o_aw, o_didx}, {3'b110, 4'd2});
    check("same_idx_dbus", o_dbus, 16'h4321);

    // LDW 0xFFFE with distinct base wraps to 0
    run_op(2'b00, 16'hFFFE, 16'h0000, 1'b1, 4'd2, 4'd4, 1, 16'h4321, 1'b0, 50);
    check("wrap_abus", {o_aw, o_abus, o_aidx}, {1'b1, 16'h0000, 4'd4});

    // Reset during REQ, then a late ack
    @(negedge clk);
    start = 1'b1; op = 2'b00; r_bus = 16'h4000; post_inc = 1'b1; dst_idx = 4'd1; base_idx = 4'd2;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_req", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("rst_req_drop", {mem_req, busy}, 2'b00);
    @(negedge clk) rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      acc = acc | {done, busy, mem_req, d_writeu, d_writel, a_write};
    end
    check("rst_late_ack", acc, 0);

`ifdef MAU_TIMEOUT_EN
    run_op(2'b00, 16'h6000, 16'h0000, 1'b1, 4'd1, 4'd2, -1, 16'h0000, 1'b0, 400);
    check("to_done_cyc", o_done_cyc, 256);
    check("to_err_writes", {o_err, o_wu, o_wl, o_aw}, 4'b1000);
    check("to_req_cycles", o_req_cyc, 255);
    run_op(2'b00, 16'h6000, 16'h0000, 1'b0, 4'd1, 4'd2, 255, 16'h7777, 1'b0, 400);
    check("to_edge_ack", {o_err, o_wu, o_wl, o_dbus, 16'(o_done_cyc)}, {3'b011, 16'h7777, 16'd256});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
